// File: rtl/stepper_platform_ctrl.sv
// Counted-step 4-phase unipolar stepper driver for one sorting platform.
// A start/done handshake wraps a RUN -> SETTLE sequence; done pulses colour_sensor_on.
module stepper_platform_ctrl #(
  parameter int STEP_CYCLES   = 97_656,
  parameter int SETTLE_CYCLES = 2_500_000,
  parameter int STEPS_W       = 16,
  parameter int POS_W         = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               dir,
  input  logic               half_step,
  input  logic [STEPS_W-1:0] num_steps,
  input  logic               abort,
  output logic [3:0]         GPIO_1,
  output logic               busy,
  output logic               done,
  output logic               colour_sensor_on,
  output logic [POS_W-1:0]   position
);

  // One counter serves both the step dwell and the settle hold.
  localparam int CNT_MAX = (STEP_CYCLES > SETTLE_CYCLES) ? STEP_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] STEP_LAST   = CNT_W'(STEP_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    SETTLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [2:0]         idx_q, idx_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [STEPS_W-1:0] rem_q, rem_d;
  logic               dir_q, dir_d;
  logic               half_q, half_d;
  logic               nz_q, nz_d;
  logic [3:0]         gpio_q, gpio_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               cso_q, cso_d;

  function automatic logic [3:0] coil_pattern(input logic [2:0] idx);
    logic [3:0] pat;
    case (idx)
      3'd0:    pat = 4'b1000;
      3'd1:    pat = 4'b1100;
      3'd2:    pat = 4'b0100;
      3'd3:    pat = 4'b0110;
      3'd4:    pat = 4'b0010;
      3'd5:    pat = 4'b0011;
      3'd6:    pat = 4'b0001;
      default: pat = 4'b1001;
    endcase
    return pat;
  endfunction

  // Full-step realigns to an even index first; in RUN the index is already even.
  function automatic logic [2:0] next_index(input logic [2:0] idx, input logic d,
                                            input logic h);
    logic [2:0] base;
    logic [2:0] step;
    base = h ? idx : {idx[2:1], 1'b0};
    step = h ? 3'd1 : 3'd2;
    return d ? base - step : base + step;
  endfunction

  function automatic logic [POS_W-1:0] next_pos(input logic [POS_W-1:0] pos, input logic d);
    return d ? pos - POS_W'(1) : pos + POS_W'(1);
  endfunction

  always_comb begin
    // NOTE: every signal gets a default up front so no path leaves one unassigned (no latches).
    state_d = state_q;
    idx_d   = idx_q;
    pos_d   = pos_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    half_d  = half_q;
    nz_d    = nz_q;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          dir_d  = dir;
          half_d = half_step;
          nz_d   = (num_steps != '0);
          rem_d  = num_steps;
          cnt_d  = '0;
          if (num_steps == '0) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
            idx_d   = next_index(idx_q, dir, half_step);
            pos_d   = next_pos(pos_q, dir);
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (cnt_q == STEP_LAST) begin
          cnt_d = '0;
          rem_d = rem_q - STEPS_W'(1);
          if (rem_q == STEPS_W'(1)) begin
            state_d = SETTLE;
          end else begin
            idx_d = next_index(idx_q, dir_q, half_q);
            pos_d = next_pos(pos_q, dir_q);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SETTLE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are derived from the next state so they can be registered without a cycle of lag.
    busy_d = (state_d == RUN) || (state_d == SETTLE);
    gpio_d = busy_d ? coil_pattern(idx_d) : 4'b0000;
    done_d = (state_d == DONE);
    cso_d  = done_d && nz_d;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      pos_q   <= '0;
      cnt_q   <= '0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      half_q  <= 1'b0;
      nz_q    <= 1'b0;
      gpio_q  <= 4'b0000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cso_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pos_q   <= pos_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      half_q  <= half_d;
      nz_q    <= nz_d;
      gpio_q  <= gpio_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cso_q   <= cso_d;
    end
  end

  assign GPIO_1           = gpio_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign colour_sensor_on = cso_q;
  assign position         = pos_q;

endmodule

// File: tb/tb_stepper_platform_ctrl.sv
// Directed bench for stepper_platform_ctrl with STEP_CYCLES=4, SETTLE_CYCLES=3.
// Inputs change and outputs are sampled on the falling edge.
module tb_stepper_platform_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        dir = 1'b0;
  logic        half_step = 1'b0;
  logic [15:0] num_steps = '0;
  logic        abort = 1'b0;
  logic [3:0]  gpio;
  logic        busy;
  logic        done;
  logic        cso;
  logic [15:0] position;

  int n_cmp = 0;
  int n_bad = 0;

  stepper_platform_ctrl #(
    .STEP_CYCLES  (4),
    .SETTLE_CYCLES(3),
    .STEPS_W      (16),
    .POS_W        (16)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .dir             (dir),
    .half_step       (half_step),
    .num_steps       (num_steps),
    .abort           (abort),
    .GPIO_1          (gpio),
    .busy            (busy),
    .done            (done),
    .colour_sensor_on(cso),
    .position        (position)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic launch(input logic d, input logic h, input logic [15:0] n);
    dir       = d;
    half_step = h;
    num_steps = n;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  // Expect a coil pattern with busy high and done low for n consecutive cycles.
  task automatic hold(input string tag, input logic [3:0] pat, input int n);
    for (int i = 0; i < n; i++) begin
      check({tag, ".gpio"}, 32'(gpio), 32'(pat));
      check({tag, ".busy"}, 32'(busy), 32'd1);
      check({tag, ".done"}, 32'(done), 32'd0);
      tick();
    end
  endtask

  task automatic expect_done(input string tag, input logic exp_cso);
    check({tag, ".gpio"}, 32'(gpio), 32'd0);
    check({tag, ".busy"}, 32'(busy), 32'd0);
    check({tag, ".done"}, 32'(done), 32'd1);
    check({tag, ".cso"},  32'(cso),  32'(exp_cso));
    tick();
    check({tag, ".done_clr"}, 32'(done), 32'd0);
    check({tag, ".cso_clr"},  32'(cso),  32'd0);
  endtask

  initial begin
    tick();
    // 1: reset state, then full-step CW 3 steps from index 0
    do_reset();
    check("rst.gpio", 32'(gpio), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.cso",  32'(cso),  32'd0);
    check("rst.pos",  32'(position), 32'd0);
    launch(1'b0, 1'b0, 16'd3);
    hold("t1.s1", 4'b0100, 4);
    hold("t1.s2", 4'b0010, 4);
    hold("t1.s3", 4'b0001, 4);
    hold("t1.settle", 4'b0001, 3);
    expect_done("t1.done", 1'b1);
    check("t1.pos", 32'(position), 32'd3);

    // 2: half-step CCW 2 steps from index 0, wraps 0->7->6
    do_reset();
    launch(1'b1, 1'b1, 16'd2);
    hold("t2.s1", 4'b1001, 4);
    hold("t2.s2", 4'b0001, 4);
    hold("t2.settle", 4'b0001, 3);
    expect_done("t2.done", 1'b1);
    check("t2.pos", 32'(position), 32'h0000_FFFE);

    // 3: half-step CW to odd index 1, then full-step realigns to 0 and steps to 2
    do_reset();
    launch(1'b0, 1'b1, 16'd1);
    hold("t3a.s1", 4'b1100, 4);
    hold("t3a.settle", 4'b1100, 3);
    expect_done("t3a.done", 1'b1);
    launch(1'b0, 1'b0, 16'd1);
    hold("t3b.s1", 4'b0100, 4);
    hold("t3b.settle", 4'b0100, 3);
    expect_done("t3b.done", 1'b1);
    check("t3.pos", 32'(position), 32'd2);

    // 4: zero-step move pulses done alone
    launch(1'b0, 1'b0, 16'd0);
    expect_done("t4.done", 1'b0);
    check("t4.pos", 32'(position), 32'd2);

    // 5: abort during the 2nd step of a 5-step move, with a same-cycle start
    do_reset();
    launch(1'b0, 1'b0, 16'd5);
    hold("t5.s1", 4'b0100, 4);
    hold("t5.s2", 4'b0010, 2);
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    check("t5.ab.gpio", 32'(gpio), 32'd0);
    check("t5.ab.busy", 32'(busy), 32'd0);
    check("t5.ab.done", 32'(done), 32'd0);
    check("t5.ab.cso",  32'(cso),  32'd0);
    check("t5.ab.pos",  32'(position), 32'd2);
    tick();
    check("t5.nostart.busy", 32'(busy), 32'd0);
    check("t5.nostart.gpio", 32'(gpio), 32'd0);
    check("t5.nostart.done", 32'(done), 32'd0);

    // 6: mid-RUN start pulse and num_steps change ignored; reset during SETTLE
    do_reset();
    launch(1'b0, 1'b0, 16'd4);
    hold("t6.s1", 4'b0100, 4);
    hold("t6.s2", 4'b0010, 1);
    start     = 1'b1;
    num_steps = 16'd1;
    hold("t6.s2", 4'b0010, 1);
    start     = 1'b0;
    hold("t6.s2", 4'b0010, 2);
    hold("t6.s3", 4'b0001, 4);
    hold("t6.s4", 4'b1000, 4);
    check("t6.pos", 32'(position), 32'd4);
    hold("t6.settle", 4'b1000, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6.rst.gpio", 32'(gpio), 32'd0);
    check("t6.rst.busy", 32'(busy), 32'd0);
    check("t6.rst.done", 32'(done), 32'd0);
    check("t6.rst.cso",  32'(cso),  32'd0);
    check("t6.rst.pos",  32'(position), 32'd0);
    tick();
    check("t6.post.done", 32'(done), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stepper_platform_ctrl.md
Name: stepper_platform_ctrl

Overview:
- Parametrised 4-phase unipolar stepper driver for the M&M sorting platforms.
- Replaces the fixed-speed, fixed-duration platform drivers with a counted-step move command.
- Adds direction, full/half-step mode, abort, a post-move settle hold, a position counter, and a start/done handshake.
- One instance per platform; on move completion it pulses colour_sensor_on for the colour sensor block.

Parameters:
- STEP_CYCLES, 97_656, clk cycles per step dwell (≥2).
- SETTLE_CYCLES, 2_500_000, clk cycles the final coil pattern is held after the last step (≥1).
- STEPS_W, 16, width of num_steps.
- POS_W, 16, width of the position counter.

Ports:
- clk  in  1  50 MHz system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  move request, sampled only in IDLE.
- dir  in  1  0 = CW (index increments), 1 = CCW; captured at start.
- half_step  in  1  1 = half-step sequence, 0 = full-step wave drive; captured at start.
- num_steps  in  STEPS_W  steps to move; captured at start.
- abort  in  1  terminate move immediately.
- GPIO_1  out  4  coil drive {A,B,C,D}.
- busy  out  1  high from the cycle after accepted start through SETTLE.
- done  out  1  one-cycle pulse on normal completion.
- colour_sensor_on  out  1  one-cycle pulse, coincident with done.
- position  out  POS_W  signed step count since reset; two's-complement wrap.

Behaviour:
- Reset (synchronous, rst high at clk edge):
  - State IDLE; GPIO_1 = 4'b0000.
  - busy, done, colour_sensor_on = 0; position = 0; phase index = 0; dwell counter = 0.
  - Reset mid-move aborts with no done pulse.
- Phase index: 3-bit, persists across moves. Pattern table, index 0..7: 1000, 1100, 0100, 0110, 0010, 0011, 0001, 1001.
  - Full-step mode uses only even indices, 2 per step.
  - Half-step mode steps by 1.
  - Arithmetic is modulo 8, covering both CW wrap (7→0 / 6→0) and CCW wrap (0→7 / 0→6).
- Full-step start: if the index is odd on an accepted full-step start, bit0 is cleared before the step is applied.
- States: IDLE, RUN, SETTLE, DONE.
- IDLE:
  - GPIO_1 = 0000.
  - On start=1 and abort=0: capture dir, half_step, num_steps.
    - If num_steps = 0: go to DONE. No motion, position unchanged.
    - Otherwise: apply the first step (index ← next index, position ± 1), set remaining = num_steps, clear the dwell counter, go to RUN.
  - GPIO_1 shows the new pattern and busy = 1 in the cycle after start is sampled.
- RUN:
  - GPIO_1 = table[index]; the dwell counter increments each cycle.
  - When the dwell counter = STEP_CYCLES−1: counter ← 0, remaining ← remaining−1.
    - If remaining was 1: go to SETTLE, index unchanged.
    - Otherwise: apply the next step.
  - Total RUN time = num_steps × STEP_CYCLES cycles; position changes by exactly num_steps.
- SETTLE:
  - Hold the last pattern for SETTLE_CYCLES cycles, then go to DONE.
- DONE (one cycle):
  - GPIO_1 = 0000, busy = 0, done = 1.
  - colour_sensor_on = 1 only if num_steps ≠ 0; a zero-step move pulses done alone.
  - Next state IDLE.
- Abort:
  - In RUN or SETTLE, abort = 1 sends the block to IDLE next cycle.
  - GPIO_1 = 0000 and busy = 0 from that cycle; no done or colour_sensor_on.
  - Position keeps the steps already taken; index is retained.
  - In IDLE, abort blocks a same-cycle start (abort wins).
  - Abort in DONE is ignored.
- Input handling:
  - start while busy or in DONE is ignored (not queued).
  - dir, half_step and num_steps changes during a move have no effect.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan (STEP_CYCLES=4, SETTLE_CYCLES=3 unless noted):
1. Reset, then full-step CW move with num_steps=3:
   - GPIO_1 = 0100, 0010, 0001, each for 4 cycles starting the cycle after start.
   - Then 0001 held 3 more cycles.
   - Then one DONE cycle: GPIO_1 = 0000, done = colour_sensor_on = 1, busy falls.
   - position = 3.
2. Half-step CCW move with num_steps=2 from index 0:
   - GPIO_1 = 1001 then 0001 (wrap 0→7→6), 4 cycles each.
   - position = −2 (0xFFFE).
3. Half-step CW num_steps=1 (index→1), then full-step CW num_steps=1:
   - Second move clears bit0 to index 0, then steps to 2: GPIO_1 = 0100.
   - Position ends at 2.
4. num_steps=0 start:
   - GPIO_1 stays 0000, busy stays 0.
   - done = 1 one cycle later, colour_sensor_on = 0, position unchanged.
5. Abort during the 2nd step of a 5-step CW move:
   - Next cycle GPIO_1 = 0000, busy = 0, no done.
   - position = 2.
   - A start asserted in the same cycle as abort is not accepted.
6. Move with num_steps=4; start re-pulsed and num_steps changed mid-RUN:
   - Both ignored; exactly 4 steps are taken.
   - Assert rst mid-SETTLE: all outputs and position return to 0 on the next edge.
